mem_arbiter: RTL
================

# mem_arbiter

Two-port-to-one-port memory arbiter that lets the instruction-fetch port and the data port of the core share a single `ram` instance (unified memory). It accepts requests through a req/gnt handshake and drives the shared RAM command one cycle after acceptance. It returns read data with a per-port valid strobe one cycle after the command. It sits between `CPU` and one `ram` instance, replacing the separate IM/DM pair in unified-memory builds.

## Interface
- `ADDR_W`, 32: address width of both ports and the RAM.
- `MAX_STREAK`, 4: maximum consecutive data grants while an instruction request waits; range 1..15.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserted when 0, clears all state immediately.
- `i_req`  in  1  instruction read request; held with `i_addr` until granted.
- `i_addr`  in  ADDR_W  instruction address.
- `i_gnt`  out  1  instruction request accepted this cycle (combinational).
- `i_rvalid`  out  1  `i_rdata` valid this cycle.
- `i_rdata`  out  32  instruction read data.
- `d_req`  in  1  data request; held with its operands until granted.
- `d_we`  in  4  byte write enables; 0 means read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  32  write data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  `d_rdata` valid this cycle; reads only.
- `d_rdata`  out  32  data read data.
- `m_addr`  out  ADDR_W  RAM address.
- `m_read`  out  1  RAM read enable.
- `m_write`  out  4  RAM byte write enables.
- `m_din`  out  32  RAM write data.
- `m_dout`  in  32  RAM read data, registered by the RAM one cycle after `m_read`.

## Operation
- **Acceptance:**
  - A request is accepted in the cycle where req and gnt are both 1.
  - At most one gnt is high per cycle.
  - Acceptance is possible every cycle; there is no back-pressure beyond arbitration.
- **Priority:**
  - The data port wins by default.
  - Exception: if `i_req`=1 and `streak`==MAX_STREAK, the instruction port wins.
- **Streak counter** (4-bit):
  - Increments on a data grant while `i_req`=1.
  - Clears on any instruction grant, or on any cycle with `i_req`=0.
  - Saturates at MAX_STREAK.
- **Command stage** (registered):
  - Holds `cmd_own` ∈ {NONE, I, D}, plus addr, we and wdata captured at acceptance.
  - Drives the `m_*` outputs. `m_read`=1 for I, or for D with we==0. `m_write`=we for D, otherwise 0.
  - With NONE, all `m_*` outputs are 0.
- **Response stage** (registered):
  - `rsp_own` takes `cmd_own` when the command was a read, otherwise NONE.
  - `i_rvalid`=(rsp_own==I), `d_rvalid`=(rsp_own==D).
  - Both rdata outputs are wired to `m_dout`; they are meaningful only while the matching rvalid is 1.
- **Writes:** no response is generated; a write completes at its command cycle.
- **Reset mid-operation:** in-flight commands and responses are dropped with no rvalid. Requesters must reissue after reset.
- **Simultaneous requests:** resolved by the priority rules above. The losing request stays pending with no timeout.

## Timing
- Acceptance at edge-cycle N: RAM command in cycle N+1, rvalid/rdata in cycle N+2.
- Fully pipelined: back-to-back acceptances produce back-to-back rvalids, in order, each tagged to its port.
- Reset values: all outputs 0; `cmd_own`=`rsp_own`=NONE; streak=0.
- gnt depends only on req inputs and streak. No combinational path from `m_dout` to any gnt.
- Worst-case instruction wait under continuous data traffic: MAX_STREAK cycles.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t`
  - localparam `STREAK_W`=4.
- One natural sub-module: `mem_arb_pick`, the combinational grant and streak-next logic (inputs `i_req`, `d_req`, streak; outputs `i_gnt`, `d_gnt`, `streak_nxt`).
- Pipeline registers and the output mux stay in `mem_arbiter`.

## Test plan
- **Reset:** pulse rst=0 mid-read (cmd_own=I) -> all outputs 0 immediately; no `i_rvalid` after release; streak=0.
- **Single fetch:** `i_req`=1, `i_addr`=0x10 with RAM word 0x00500093 -> `i_gnt` at N; `m_read`=1, `m_addr`=0x10 at N+1; `i_rvalid`=1, `i_rdata`=0x00500093 at N+2.
- **Data write:** `d_we`=4'b0011, `d_addr`=0x40, `d_wdata`=0xDEADBEEF -> `m_write`=0011 at N+1; later read of 0x40 returns low half 0xBEEF; `d_rvalid` never pulses for the write.
- **Simultaneous requests:** `i_req`=`d_req`=1 with streak 0 -> `d_gnt`=1, `i_gnt`=0; `i_gnt` follows the next cycle when `d_req` drops.
- **Starvation guard:** `d_req` held 1 for 10 cycles, `i_req`=1, MAX_STREAK=4 -> grants D,D,D,D,I,D,D,D,D,I.
- **Pipelining:** alternating I/D reads at 0x0, 0x4, 0x8 on consecutive cycles -> rvalids on consecutive cycles, in order, each with the correct port and data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Port ownership tags and streak counter width.
package mem_arb_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } own_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection and streak-next logic.
// In: i_req, d_req, streak. Out: i_gnt, d_gnt, streak_nxt.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                i_gnt,
  output logic                d_gnt,
  output logic [STREAK_W-1:0] streak_nxt
);

  localparam logic [STREAK_W-1:0] MAX =
    STREAK_W'(MAX_STREAK);

  logic starve;

  // Data wins unless fetch has waited out its streak.
  assign starve = i_req && (streak == MAX);
  assign d_gnt  = d_req && !starve;
  assign i_gnt  = i_req && !d_gnt;

  always_comb begin
    streak_nxt = '0;
    if (i_req && d_gnt) begin
      if (streak == MAX)
        streak_nxt = MAX;
      else
        streak_nxt = streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to one RAM port arbiter.
// Ports: i_* fetch, d_* data, m_* shared RAM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic [3:0]        m_write,
  output logic [31:0]       m_din,
  input  logic [31:0]       m_dout
);

  own_t                cmd_own;
  own_t                rsp_own;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [3:0]          cmd_we;
  logic [31:0]         cmd_wdata;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_nxt;
  logic                cmd_rd;
  logic                cmd_d;

  mem_arb_pick #(
    .MAX_STREAK(MAX_STREAK)
  ) u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .streak    (streak_q),
    .i_gnt     (i_gnt),
    .d_gnt     (d_gnt),
    .streak_nxt(streak_nxt)
  );

  assign cmd_d  = (cmd_own == OWN_D);
  assign cmd_rd = (cmd_own == OWN_I) ||
                  (cmd_d && cmd_we == 4'b0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_own   <= OWN_NONE;
      rsp_own   <= OWN_NONE;
      cmd_addr  <= '0;
      cmd_we    <= '0;
      cmd_wdata <= '0;
      streak_q  <= '0;
    end else begin
      streak_q <= streak_nxt;
      unique case (1'b1)
        i_gnt: begin
          cmd_own   <= OWN_I;
          cmd_addr  <= i_addr;
          cmd_we    <= '0;
          cmd_wdata <= '0;
        end
        d_gnt: begin
          cmd_own   <= OWN_D;
          cmd_addr  <= d_addr;
          cmd_we    <= d_we;
          cmd_wdata <= d_wdata;
        end
        default: cmd_own <= OWN_NONE;
      endcase
      // Writes retire at the command cycle.
      rsp_own <= cmd_rd ? cmd_own : OWN_NONE;
    end
  end

  assign m_addr  = (cmd_own != OWN_NONE) ?
                   cmd_addr : '0;
  assign m_read  = cmd_rd;
  assign m_write = cmd_d ? cmd_we : 4'b0;
  assign m_din   = cmd_d ? cmd_wdata : 32'b0;

  assign i_rvalid = (rsp_own == OWN_I);
  assign d_rvalid = (rsp_own == OWN_D);
  assign i_rdata  = m_dout;
  assign d_rdata  = m_dout;

endmodule
